// File: rtl/count_sequencer.sv
// Run controller for a loadable up-counter: preload, prescaled stepping to a
// limit, optional wrap-and-repeat, with start/pause/abort pulse controls.
module count_sequencer #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic                   wrap_en,
  input  logic [WIDTH-1:0]       preset,
  input  logic [WIDTH-1:0]       limit,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic [WIDTH-1:0]       count,
  output logic                   ld,
  output logic                   en,
  output logic [WIDTH-1:0]       v,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             lap_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t                 state, state_nx;
  logic [PRESC_WIDTH-1:0] psc, psc_nx;
  logic [WIDTH-1:0]       v_nx;
  logic [7:0]             lap_nx;
  logic                   at_lim, tick;

  assign at_lim = (count == limit);
  assign tick   = (psc == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      psc     <= '0;
      v       <= '0;
      lap_cnt <= '0;
    end else begin
      state   <= state_nx;
      psc     <= psc_nx;
      v       <= v_nx;
      lap_cnt <= lap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    psc_nx   = psc;
    v_nx     = v;
    lap_nx   = lap_cnt;
    if (abort) begin
      state_nx = IDLE;
      psc_nx   = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nx = LOAD;
          v_nx     = preset;
          lap_nx   = '0;
        end
        LOAD: begin
          state_nx = RUN;
          psc_nx   = '0;
        end
        // limit check outranks pause; pause freezes the prescaler phase
        RUN: begin
          if (at_lim)      state_nx = DONE;
          else if (pause)  state_nx = PAUSE;
          else if (tick)   psc_nx   = '0;
          else             psc_nx   = psc + PRESC_WIDTH'(1);
        end
        PAUSE: if (pause) state_nx = RUN;
        DONE: begin
          if (lap_cnt != 8'hFF) lap_nx = lap_cnt + 8'd1;
          if (wrap_en) begin
            state_nx = LOAD;
            v_nx     = preset;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign ld   = (state == LOAD);
  assign done = (state == DONE);
  assign busy = (state != IDLE);
  assign en   = (state == RUN) && tick && !at_lim;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboarded bench for count_sequencer: each run's ld/en/done events are
// predicted arithmetically and matched by a monitor against the DUT.
module tb_count_sequencer;
  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 0, rst = 1;
  logic          start = 0, pause = 0, abort = 0, wrap_en = 0;
  logic [W-1:0]  preset = '0, limit = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  count;
  logic          ld, en, busy, done;
  logic [W-1:0]  v;
  logic [7:0]    lap_cnt;

  count_sequencer #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .wrap_en(wrap_en), .preset(preset), .limit(limit), .presc(presc),
    .count(count), .ld(ld), .en(en), .v(v), .busy(busy), .done(done),
    .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  // the counter being controlled: ld wins over en
  always_ff @(posedge clk or posedge rst)
    if (rst)     count <= '0;
    else if (ld) count <= v;
    else if (en) count <= count + 8'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_LD = 0, K_EN = 1, K_DONE = 2;
  typedef struct { int kind; int cyc; int val; } ev_t;
  ev_t q[$];

  int checks = 0, errors = 0;
  int lapm = 0, cntm = 0;
  bit mon_on = 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int t, input int val);
    ev_t e;
    e.kind = k; e.cyc = t; e.val = val;
    q.push_back(e);
  endtask

  task automatic chk_ev(input int k, input int val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d expected none", k, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d val %0d expected kind %0d cyc %0d val %0d",
                 k, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) if (!rst && mon_on) begin
    if (ld)   chk_ev(K_LD, int'(v));
    if (en)   chk_ev(K_EN, int'(count));
    if (done) chk_ev(K_DONE, 0);
  end

  // One run from IDLE. poff: pause offset from RUN entry (-1 none), plen: cycles
  // until the resume pulse; aoff: abort offset from the start cycle (-1 none).
  task automatic run(input int pr, input int lm, input int ps, input int laps,
                     input int poff, input int plen, input int aoff, input bit stray);
    int s, n, lim_idx, F, pabs, aabs, base, t, last_done, tend;
    bit pz, pign, cut;
    preset = pr[W-1:0]; limit = lm[W-1:0]; presc = ps[PW-1:0];
    s = cyc;
    n = (lm - pr) & 255;
    lim_idx = n * (ps + 1);
    pz = (poff >= 0);
    pign = pz && (poff >= lim_idx);
    F = (pz && !pign) ? plen + 1 : 0;
    pabs = s + 2 + poff;
    aabs = (aoff >= 0) ? s + aoff : 32'h7fffffff;
    lapm = 0; base = s; last_done = s; cut = 0;
    for (int L = 0; L < laps && !cut; L++) begin
      t = base + 1;
      if (t > aabs) begin cut = 1; break; end
      push(K_LD, t, pr & 255);
      cntm = pr & 255;
      for (int j = 0; j < n; j++) begin
        t = base + 2 + ps + j * (ps + 1);
        if (L == 0 && F > 0 && t >= pabs) t += F;
        if (t > aabs) begin cut = 1; break; end
        push(K_EN, t, cntm);
        cntm = (cntm + 1) & 255;
      end
      if (cut) break;
      t = base + 2 + lim_idx + 1;
      if (L == 0 && F > 0) t += F;
      if (t > aabs) begin cut = 1; break; end
      push(K_DONE, t, 0);
      if (t < aabs && lapm < 255) lapm++;
      last_done = t;
      base = t;
    end
    tend = (aoff >= 0) ? aabs : last_done;
    for (int c = s; c <= tend; c++) begin
      start   = (c == s) || (stray && c == s + 2);
      pause   = pz && (c == pabs || (!pign && c == pabs + plen));
      abort   = (aoff >= 0) && (c == aabs);
      wrap_en = (laps > 1) && (aoff >= 0 || c < last_done);
      @(posedge clk); #1;
    end
    start = 0; pause = 0; abort = 0; wrap_en = 0;
    @(negedge clk); #1;
    chk("busy_after_run", int'(busy), 0);
    chk("lap_cnt", int'(lap_cnt), lapm);
    chk("count_after_run", int'(count), cntm);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pr, n, ps, laps, mode, poff, plen, aoff;
    #3;
    chk("rst_ld", int'(ld), 0);     chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0); chk("rst_done", int'(done), 0);
    chk("rst_v", int'(v), 0);       chk("rst_lap", int'(lap_cnt), 0);
    #20 rst = 0;
    @(posedge clk); #1;

    run(3, 7, 0, 1, -1, 0, -1, 0);               // basic, presc 0
    run(0, 2, 2, 1, -1, 0, -1, 1);               // prescaled, stray start ignored
    run(0, 1, 0, 1000, -1, 0, 1203, 0);          // 300 laps, saturate, then abort
    run(0, 6, 3, 1, 5, 10, -1, 0);               // pause/resume keeps phase
    run(0, 2, 3, 1, 8, 0, -1, 0);                // pause on limit cycle dropped
    run(0, 9, 1, 1, -1, 0, 12, 0);               // abort at count 5
    run(9, 9, 2, 1, -1, 0, -1, 0);               // preset == limit
    run(250, 3, 0, 1, -1, 0, -1, 0);             // preset > limit wraps

    // start together with abort in IDLE must not launch a run
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    repeat (4) @(posedge clk);
    #1 chk("start_abort_busy", int'(busy), 0);

    for (int r = 0; r < 40; r++) begin
      pr = $urandom_range(0, 255); n = $urandom_range(0, 5);
      ps = $urandom_range(0, 3);   laps = $urandom_range(1, 3);
      mode = $urandom_range(0, 2); poff = -1; plen = 0; aoff = -1;
      if (mode == 1 && ps >= 1 && n >= 1) begin
        laps = 1;
        poff = $urandom_range(0, n * (ps + 1) - 1);
        if (poff % (ps + 1) == ps) poff--;
        plen = $urandom_range(1, 10);
      end else if (mode == 2) begin
        aoff = 2 + $urandom_range(0, n * (ps + 1) + 1);
      end
      run(pr, (pr + n) & 255, ps, laps, poff, plen, aoff, ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset in the middle of a run
    mon_on = 0;
    preset = 8'd9; limit = 8'd20; presc = '0;
    start = 1;
    @(posedge clk); #1; start = 0;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_en", int'(en), 1);
    #2 rst = 1;
    #1;
    chk("arst_ld", int'(ld), 0);     chk("arst_en", int'(en), 0);
    chk("arst_busy", int'(busy), 0); chk("arst_done", int'(done), 0);
    chk("arst_v", int'(v), 0);       chk("arst_lap", int'(lap_cnt), 0);
    #10 rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
